// File: rtl/openmips_min_sopc_if.sv
// Data-memory bus between the openmips core and the data RAM.
// widx is the word index; be selects byte lanes (be[3] = bits 31:24).
interface openmips_min_sopc_if #(
  parameter int AW = 10
);
  logic [AW-1:0] widx;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic [31:0]   rdata;

  modport master (output widx, output wdata, output be, input rdata);
  modport slave  (input widx, input wdata, input be, output rdata);
endinterface

// File: rtl/openmips_min_sopc.sv
// Minimal SOPC: single-cycle MIPS32-subset core, instruction ROM and byte-banked data RAM.
// Optional lb/lbu/sb support is enabled by defining OPENMIPS_SOPC_BYTE_ACCESS_EN.

module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regs [0:31];

  // $0 never matches a write, so it stays at its reset value of zero.
  for (genvar gi = 0; gi < 32; gi++) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst)
        regs[gi] <= '0;
      else if (we && waddr != 5'd0 && waddr == 5'(gi))
        regs[gi] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];
endmodule

module inst_rom #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   inst
);
  logic [31:0] inst_mem [0:WORDS-1];

  assign inst = inst_mem[addr];
endmodule

module data_ram #(
  parameter int WORDS = 1024
) (
  input logic clk,
  openmips_min_sopc_if.slave bus
);
  logic [7:0] bank0 [0:WORDS-1];
  logic [7:0] bank1 [0:WORDS-1];
  logic [7:0] bank2 [0:WORDS-1];
  logic [7:0] bank3 [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (bus.be[3]) bank3[bus.widx] <= bus.wdata[31:24];
    if (bus.be[2]) bank2[bus.widx] <= bus.wdata[23:16];
    if (bus.be[1]) bank1[bus.widx] <= bus.wdata[15:8];
    if (bus.be[0]) bank0[bus.widx] <= bus.wdata[7:0];
  end

  assign bus.rdata = {bank3[bus.widx], bank2[bus.widx], bank1[bus.widx], bank0[bus.widx]};
endmodule

module openmips #(
  parameter int IAW = 10,
  parameter int DAW = 10
) (
  input  logic           clk,
  input  logic           rst,
  output logic [IAW-1:0] rom_addr,
  input  logic [31:0]    inst,
  openmips_min_sopc_if.master ram
);
  logic [31:0] pc_reg, npc_reg;
  logic [31:0] rs_val, rt_val;
  logic [31:0] sext_imm, zext_imm, pc_plus4, mem_addr, br_target;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic        wb_en, taken;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, target;
  logic [3:0]  be;
  logic        unused_addr_bits;
`ifdef OPENMIPS_SOPC_BYTE_ACCESS_EN
  logic [7:0]  ld_byte;
`endif

  assign op       = inst[31:26];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign rd       = inst[15:11];
  assign sa       = inst[10:6];
  assign funct    = inst[5:0];
  assign sext_imm = {{16{inst[15]}}, inst[15:0]};
  assign zext_imm = {16'h0, inst[15:0]};
  assign pc_plus4 = pc_reg + 32'd4;
  assign br_target = pc_plus4 + {sext_imm[29:0], 2'b00};
  assign mem_addr = rs_val + sext_imm;
  assign rom_addr = pc_reg[IAW+1:2];
  assign ram.widx = mem_addr[DAW+1:2];
  assign ram.be   = rst ? 4'b0000 : be;
  assign unused_addr_bits = ^{mem_addr[31:DAW+2], mem_addr[1:0]};

  regfile regfile1 (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en & ~rst),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rs_val),
    .rdata2 (rt_val)
  );

`ifdef OPENMIPS_SOPC_BYTE_ACCESS_EN
  // Byte offset 0 is the most significant byte (big-endian).
  always_comb begin
    ld_byte = ram.rdata[7:0];
    case (mem_addr[1:0])
      2'd0: ld_byte = ram.rdata[31:24];
      2'd1: ld_byte = ram.rdata[23:16];
      2'd2: ld_byte = ram.rdata[15:8];
      default: ld_byte = ram.rdata[7:0];
    endcase
  end
`endif

  always_comb begin
    wb_en     = 1'b0;
    wb_addr   = rt;
    wb_data   = 32'd0;
    be        = 4'b0000;
    ram.wdata = rt_val;
    taken     = 1'b0;
    target    = 32'd0;
    case (op)
      6'h00: begin
        wb_addr = rd;
        wb_en   = 1'b1;
        case (funct)
          6'h21: wb_data = rs_val + rt_val;
          6'h23: wb_data = rs_val - rt_val;
          6'h24: wb_data = rs_val & rt_val;
          6'h25: wb_data = rs_val | rt_val;
          6'h26: wb_data = rs_val ^ rt_val;
          6'h27: wb_data = ~(rs_val | rt_val);
          6'h2a: wb_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
          6'h00: wb_data = rt_val << sa;
          6'h02: wb_data = rt_val >> sa;
          6'h03: wb_data = $unsigned($signed(rt_val) >>> sa);
          6'h08: begin
            wb_en  = 1'b0;
            taken  = 1'b1;
            target = rs_val;
          end
          default: wb_en = 1'b0;
        endcase
      end
      6'h09: begin wb_en = 1'b1; wb_data = rs_val + sext_imm; end
      6'h0a: begin wb_en = 1'b1; wb_data = {31'd0, $signed(rs_val) < $signed(sext_imm)}; end
      6'h0c: begin wb_en = 1'b1; wb_data = rs_val & zext_imm; end
      6'h0d: begin wb_en = 1'b1; wb_data = rs_val | zext_imm; end
      6'h0e: begin wb_en = 1'b1; wb_data = rs_val ^ zext_imm; end
      6'h0f: begin wb_en = 1'b1; wb_data = {inst[15:0], 16'h0}; end
      6'h23: begin wb_en = 1'b1; wb_data = ram.rdata; end
      6'h2b: be = 4'b1111;
      6'h04: begin taken = (rs_val == rt_val); target = br_target; end
      6'h05: begin taken = (rs_val != rt_val); target = br_target; end
      6'h02: begin taken = 1'b1; target = {pc_plus4[31:28], inst[25:0], 2'b00}; end
      6'h03: begin
        taken   = 1'b1;
        target  = {pc_plus4[31:28], inst[25:0], 2'b00};
        wb_en   = 1'b1;
        wb_addr = 5'd31;
        wb_data = pc_reg + 32'd8;
      end
`ifdef OPENMIPS_SOPC_BYTE_ACCESS_EN
      6'h20: begin wb_en = 1'b1; wb_data = {{24{ld_byte[7]}}, ld_byte}; end
      6'h24: begin wb_en = 1'b1; wb_data = {24'd0, ld_byte}; end
      6'h28: begin
        be        = 4'b1000 >> mem_addr[1:0];
        ram.wdata = {4{rt_val[7:0]}};
      end
`endif
      default: ;
    endcase
  end

  // npc holds the delay-slot address; a taken branch redirects the fetch after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg  <= 32'd0;
      npc_reg <= 32'd4;
    end else begin
      pc_reg  <= npc_reg;
      npc_reg <= taken ? target : npc_reg + 32'd4;
    end
  end
endmodule

module openmips_min_sopc #(
  parameter int INST_ROM_WORDS = 1024,
  parameter int DATA_RAM_WORDS = 1024
) (
  input logic clk,
  input logic rst
);
  localparam int IAW = $clog2(INST_ROM_WORDS);
  localparam int DAW = $clog2(DATA_RAM_WORDS);

  logic [IAW-1:0] rom_addr;
  logic [31:0]    inst;

  openmips_min_sopc_if #(.AW(DAW)) ram_bus ();

  openmips #(.IAW(IAW), .DAW(DAW)) openmips0 (
    .clk      (clk),
    .rst      (rst),
    .rom_addr (rom_addr),
    .inst     (inst),
    .ram      (ram_bus)
  );

  inst_rom #(.WORDS(INST_ROM_WORDS)) inst_rom0 (
    .addr (rom_addr),
    .inst (inst)
  );

  data_ram #(.WORDS(DATA_RAM_WORDS)) data_ram0 (
    .clk (clk),
    .bus (ram_bus)
  );
endmodule

// File: tb/tb_openmips_min_sopc.sv
// Directed-program bench for openmips_min_sopc; loads the ROM hierarchically and checks state.
module tb_openmips_min_sopc;
  logic clk;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  openmips_min_sopc dut (
    .clk (clk),
    .rst (rst)
  );

  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 1024; i++) dut.inst_rom0.inst_mem[i] = 32'h0;
  endtask

  task automatic rom(input int idx, input logic [31:0] val);
    dut.inst_rom0.inst_mem[idx] = val;
  endtask

  task automatic reset_start();
    @(negedge clk);
    rst = 1'b1;
    rom_clear();
  endtask

  task automatic reset_release_run(input int n);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] regs_or();
    logic [31:0] acc = 32'h0;
    for (int i = 0; i < 32; i++) acc |= dut.openmips0.regfile1.regs[i];
    return acc;
  endfunction

  initial begin
    // lui/ori with reset held for 25 ns
    rst = 1'b1;
    rom_clear();
    rom(0, 32'h3C010101);
    rom(1, 32'h34210101);
    #25;
    chk("reset_pc", dut.openmips0.pc_reg, 32'h0);
    chk("reset_npc", dut.openmips0.npc_reg, 32'h4);
    chk("reset_regs", regs_or(), 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lui_ori_r1", dut.openmips0.regfile1.regs[1], 32'h01010101);

    // sw / lw word, big-endian banks
    reset_start();
    rom(0, 32'h34021234);
    rom(1, 32'hAC020000);
    rom(2, 32'h8C030000);
    reset_release_run(3);
    chk("sw_bank3", {24'h0, dut.data_ram0.bank3[0]}, 32'h00);
    chk("sw_bank2", {24'h0, dut.data_ram0.bank2[0]}, 32'h00);
    chk("sw_bank1", {24'h0, dut.data_ram0.bank1[0]}, 32'h12);
    chk("sw_bank0", {24'h0, dut.data_ram0.bank0[0]}, 32'h34);
    chk("lw_r3", dut.openmips0.regfile1.regs[3], 32'h00001234);

    // beq with delay slot
    reset_start();
    rom(0, 32'h34010001);
    rom(1, 32'h10000002);
    rom(2, 32'h34020005);
    rom(3, 32'h34030007);
    rom(4, 32'h34040009);
    reset_release_run(5);
    chk("beq_r1", dut.openmips0.regfile1.regs[1], 32'h1);
    chk("beq_slot_r2", dut.openmips0.regfile1.regs[2], 32'h5);
    chk("beq_skip_r3", dut.openmips0.regfile1.regs[3], 32'h0);
    chk("beq_tgt_r4", dut.openmips0.regfile1.regs[4], 32'h9);

    // $0 immutability and modular add
    reset_start();
    rom(0, 32'h3400FFFF);
    rom(1, 32'h2405FFFF);
    rom(2, 32'h00A53021);
    reset_release_run(3);
    chk("r0_zero", dut.openmips0.regfile1.regs[0], 32'h0);
    chk("addiu_r5", dut.openmips0.regfile1.regs[5], 32'hFFFFFFFF);
    chk("addu_r6", dut.openmips0.regfile1.regs[6], 32'hFFFFFFFE);

    // byte access (RAM word 0 currently holds 0x00001234)
    reset_start();
    rom(0, 32'h340100AB);
    rom(1, 32'hA0010002);
    rom(2, 32'h80020002);
    rom(3, 32'h90030002);
    reset_release_run(4);
    chk("sb_bank3", {24'h0, dut.data_ram0.bank3[0]}, 32'h00);
    chk("sb_bank2", {24'h0, dut.data_ram0.bank2[0]}, 32'h00);
    chk("sb_bank0", {24'h0, dut.data_ram0.bank0[0]}, 32'h34);
`ifdef OPENMIPS_SOPC_BYTE_ACCESS_EN
    chk("sb_bank1", {24'h0, dut.data_ram0.bank1[0]}, 32'hAB);
    chk("lb_r2", dut.openmips0.regfile1.regs[2], 32'hFFFFFFAB);
    chk("lbu_r3", dut.openmips0.regfile1.regs[3], 32'h000000AB);
`else
    chk("sb_nop_bank1", {24'h0, dut.data_ram0.bank1[0]}, 32'h12);
    chk("lb_nop_r2", dut.openmips0.regfile1.regs[2], 32'h0);
    chk("lbu_nop_r3", dut.openmips0.regfile1.regs[3], 32'h0);
`endif

    // shifts, slt, jal/jr with delay slots
    reset_start();
    rom(0, 32'h3C018000);
    rom(1, 32'h00011103);
    rom(2, 32'h00011902);
    rom(3, 32'h0020202A);
    rom(4, 32'h0C000008);
    rom(5, 32'h34050003);
    rom(6, 32'h34060001);
    rom(8, 32'h03E00008);
    rom(9, 32'h34070007);
    reset_release_run(12);
    chk("sra_r2", dut.openmips0.regfile1.regs[2], 32'hF8000000);
    chk("srl_r3", dut.openmips0.regfile1.regs[3], 32'h08000000);
    chk("slt_r4", dut.openmips0.regfile1.regs[4], 32'h1);
    chk("jal_slot_r5", dut.openmips0.regfile1.regs[5], 32'h3);
    chk("jal_r31", dut.openmips0.regfile1.regs[31], 32'h18);
    chk("jr_slot_r7", dut.openmips0.regfile1.regs[7], 32'h7);
    chk("jr_ret_r6", dut.openmips0.regfile1.regs[6], 32'h1);

    // reset mid-program with a branch pending in the delay slot
    reset_start();
    rom(0, 32'h34010001);
    rom(1, 32'h10000002);
    rom(2, 32'h34020005);
    rom(3, 32'h34030007);
    rom(4, 32'h34040009);
    reset_release_run(2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_pc", dut.openmips0.pc_reg, 32'h0);
    chk("midrst_npc", dut.openmips0.npc_reg, 32'h4);
    chk("midrst_regs", regs_or(), 32'h0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rerun_r1", dut.openmips0.regfile1.regs[1], 32'h1);
    chk("rerun_r2", dut.openmips0.regfile1.regs[2], 32'h5);
    chk("rerun_r3", dut.openmips0.regfile1.regs[3], 32'h0);
    chk("rerun_r4", dut.openmips0.regfile1.regs[4], 32'h9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
